// File: rtl/emisor_instrucciones_if.sv
// Instruction bus between the sequencer and the register-file/ALU datapath.
// Ports: instr/instr_valid driven by the sequencer (master); instr_ready and
//        zflow (zero flag for the word on instr) driven by the datapath (slave).
interface emisor_instrucciones_if #(
  parameter int IW = 20
);
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          zflow;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready,
    input  zflow
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready,
    output zflow
  );
endinterface

// File: rtl/emisor_instrucciones.sv
// Program sequencer: host loads up to DEPTH instruction words, start issues
// them one per accepted valid/ready handshake, counting zero-flag results.
// Ports: clk/rst, host load (wr_en, wr_data, clr, start), datapath bus (dp),
//        status (busy, done pulse, pc, count, saturating zero_cnt).
module emisor_instrucciones #(
  parameter  int DEPTH = 16,
  parameter  int IW    = 20,
  parameter  int ZW    = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IW-1:0]          wr_data,
  input  logic                   clr,
  input  logic                   start,
  emisor_instrucciones_if.master dp,
  output logic                   busy,
  output logic                   done,
  output logic [PW-1:0]          pc,
  output logic [CW-1:0]          count,
  output logic [ZW-1:0]          zero_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t        state;
  logic [IW-1:0] mem [DEPTH];

  logic          wr_fire;
  logic          accept;
  logic          last;
  logic [PW-1:0] pc_nxt;

  // clr outranks wr_en; a full buffer silently drops the write.
  assign wr_fire = (state == IDLE) && !clr && wr_en && (count != FULL);
  assign accept  = dp.instr_valid & dp.instr_ready;
  // count is nonzero whenever RUN is entered, so count-1 never underflows here.
  assign last    = ({1'b0, pc} == (count - CW'(1)));
  assign pc_nxt  = pc + PW'(1);

  // Buffer storage carries no reset: contents are meaningless until count covers them.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[count[PW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      dp.instr       <= '0;
      dp.instr_valid <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pc             <= '0;
      count          <= '0;
      zero_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            count <= '0;
          end else if (wr_en) begin
            // start in the same cycle is ignored; the write wins.
            if (count != FULL) count <= count + CW'(1);
          end else if (start) begin
            zero_cnt <= '0;
            pc       <= '0;
            if (count != '0) begin
              dp.instr       <= mem[0];
              dp.instr_valid <= 1'b1;
              busy           <= 1'b1;
              state          <= RUN;
            end else begin
              // Empty program: skip straight to the completion pulse.
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        RUN: begin
          if (accept) begin
            if (dp.zflow && (zero_cnt != '1)) zero_cnt <= zero_cnt + ZW'(1);
            if (last) begin
              dp.instr_valid <= 1'b0;
              busy           <= 1'b0;
              done           <= 1'b1;
              state          <= DONE;
            end else begin
              pc       <= pc_nxt;
              dp.instr <= mem[pc_nxt];
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_emisor_instrucciones.sv
// Directed bench for emisor_instrucciones: a DEPTH=16/ZW=8 instance plus a
// ZW=2 instance driven by the same inputs for the saturation case.
// Ports: none; drives clk/rst, host load signals and the datapath side of both buses.
module tb_emisor_instrucciones;

  localparam int IW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_data = '0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic          rdy = 1'b0;
  logic          zf = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  emisor_instrucciones_if #(.IW(IW)) bus  ();
  emisor_instrucciones_if #(.IW(IW)) bus2 ();

  assign bus.instr_ready  = rdy;
  assign bus.zflow        = zf;
  assign bus2.instr_ready = rdy;
  assign bus2.zflow       = zf;

  logic       busy, done;
  logic [3:0] pc;
  logic [4:0] count;
  logic [7:0] zero_cnt;

  logic       busy2, done2;
  logic [3:0] pc2;
  logic [4:0] count2;
  logic [1:0] zero_cnt2;

  emisor_instrucciones #(.DEPTH(16), .IW(IW), .ZW(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .start(start), .dp(bus.master), .busy(busy), .done(done), .pc(pc),
    .count(count), .zero_cnt(zero_cnt)
  );

  emisor_instrucciones #(.DEPTH(16), .IW(IW), .ZW(2)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .start(start), .dp(bus2.master), .busy(busy2), .done(done2), .pc(pc2),
    .count(count2), .zero_cnt(zero_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [IW-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    tick();
    wr_en   = 1'b0;
  endtask

  localparam logic [IW-1:0] W0 = 20'h8A0C1;
  localparam logic [IW-1:0] W1 = 20'h40421;
  localparam logic [IW-1:0] W2 = 20'hC1463;

  bit seen;

  initial begin
    // Reset, then idle
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_instr",  32'(bus.instr), 32'h0);
    chk("rst_valid",  32'(bus.instr_valid), 32'h0);
    chk("rst_busy",   32'(busy), 32'h0);
    chk("rst_done",   32'(done), 32'h0);
    chk("rst_pc",     32'(pc), 32'h0);
    chk("rst_count",  32'(count), 32'h0);
    chk("rst_zcnt",   32'(zero_cnt), 32'h0);

    // Three-word program, continuous ready
    write_word(W0); write_word(W1); write_word(W2);
    chk("load3_count", 32'(count), 32'd3);
    rdy = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("r1_instr0", 32'(bus.instr), 32'(W0));
    chk("r1_valid0", 32'(bus.instr_valid), 32'h1);
    chk("r1_pc0",    32'(pc), 32'd0);
    chk("r1_busy0",  32'(busy), 32'h1);
    chk("r1_instr0_d2", 32'(bus2.instr), 32'(W0));
    tick();
    chk("r1_instr1", 32'(bus.instr), 32'(W1));
    chk("r1_pc1",    32'(pc), 32'd1);
    tick();
    chk("r1_instr2", 32'(bus.instr), 32'(W2));
    chk("r1_pc2",    32'(pc), 32'd2);
    chk("r1_pc2_d2", 32'(pc2), 32'd2);
    tick();
    chk("r1_done",   32'(done), 32'h1);
    chk("r1_valid_end", 32'(bus.instr_valid), 32'h0);
    chk("r1_busy_end",  32'(busy), 32'h0);
    chk("r1_instr_hold", 32'(bus.instr), 32'(W2));
    chk("r1_count",  32'(count), 32'd3);
    tick();
    chk("r1_done_pulse", 32'(done), 32'h0);

    // Same program, ready low for two cycles while word 1 is shown
    start = 1'b1;
    tick(); start = 1'b0;
    chk("r2_instr0", 32'(bus.instr), 32'(W0));
    tick();
    chk("r2_instr1a", 32'(bus.instr), 32'(W1));
    rdy = 1'b0;
    tick();
    chk("r2_instr1b", 32'(bus.instr), 32'(W1));
    chk("r2_pc1b",    32'(pc), 32'd1);
    tick();
    chk("r2_instr1c", 32'(bus.instr), 32'(W1));
    chk("r2_valid1c", 32'(bus.instr_valid), 32'h1);
    rdy = 1'b1;
    tick();
    chk("r2_instr2", 32'(bus.instr), 32'(W2));
    chk("r2_done_early", 32'(done), 32'h0);
    tick();
    chk("r2_done", 32'(done), 32'h1);
    chk("r2_done_d2", 32'(done2), 32'h1);
    tick();

    // clr together with wr_en empties the buffer
    clr = 1'b1; wr_en = 1'b1; wr_data = 20'h12345;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    chk("clr_wr_count", 32'(count), 32'd0);

    // Fill past capacity
    for (int i = 0; i < 17; i++) write_word(20'(i * 37 + 5));
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_count_d2", 32'(count2), 32'd16);

    // Writes and clr during RUN are ignored
    start = 1'b1;
    tick(); start = 1'b0;
    chk("r16_instr0", 32'(bus.instr), 32'd5);
    wr_en = 1'b1; clr = 1'b1; wr_data = 20'hFFFFF;
    tick();
    wr_en = 1'b0; clr = 1'b0;
    chk("run_wr_count", 32'(count), 32'd16);
    chk("run_wr_busy",  32'(busy), 32'h1);
    chk("r16_instr1", 32'(bus.instr), 32'd42);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("r16_done_seen", 32'(seen), 32'h1);
    chk("r16_last_instr", 32'(bus.instr), 32'(15 * 37 + 5));
    tick();

    // Empty program: start goes straight to a done pulse
    clr = 1'b1;
    tick(); clr = 1'b0;
    start = 1'b1;
    tick(); start = 1'b0;
    chk("empty_valid", 32'(bus.instr_valid), 32'h0);
    chk("empty_busy",  32'(busy), 32'h0);
    chk("empty_done",  32'(done), 32'h1);
    tick();
    chk("empty_done_end", 32'(done), 32'h0);

    // start with wr_en: write taken, stays idle
    wr_en = 1'b1; start = 1'b1; wr_data = 20'h0ABCD;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("start_wr_count", 32'(count), 32'd1);
    chk("start_wr_busy",  32'(busy), 32'h0);
    chk("start_wr_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    chk("start_wr_nodone", 32'(done), 32'h0);

    // Four-word program, zflow on accepts 1 and 3 plus a non-accept cycle
    clr = 1'b1;
    tick(); clr = 1'b0;
    write_word(20'h11111); write_word(20'h22222);
    write_word(20'h33333); write_word(20'h44444);
    rdy = 1'b1; zf = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk("z_start_zcnt", 32'(zero_cnt), 32'd0);
    zf = 1'b1; tick();
    chk("z_acc1", 32'(zero_cnt), 32'd1);
    rdy = 1'b0; zf = 1'b1; tick();
    chk("z_noacc", 32'(zero_cnt), 32'd1);
    rdy = 1'b1; zf = 1'b0; tick();
    zf = 1'b1; tick();
    zf = 1'b0; tick();
    chk("z_done",  32'(done), 32'h1);
    chk("z_total", 32'(zero_cnt), 32'd2);
    chk("z_total_d2", 32'(zero_cnt2), 32'd2);
    tick(); tick();
    chk("z_hold_idle", 32'(zero_cnt), 32'd2);

    // Rerun with zflow held high: the 2-bit counter saturates at 3
    start = 1'b1;
    tick(); start = 1'b0;
    chk("zs_restart", 32'(zero_cnt2), 32'd0);
    zf = 1'b1;
    tick(); tick(); tick(); tick();
    zf = 1'b0;
    chk("zs_done_d2",  32'(done2), 32'h1);
    chk("zs_sat_d2",   32'(zero_cnt2), 32'd3);
    chk("zs_full_d1",  32'(zero_cnt), 32'd4);
    tick();

    // Reset in the middle of a run
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("mid_busy_before", 32'(busy), 32'h1);
    chk("mid_busy_before_d2", 32'(busy2), 32'h1);
    rst = 1'b1;
    #2;
    chk("mid_valid", 32'(bus.instr_valid), 32'h0);
    chk("mid_busy",  32'(busy), 32'h0);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_pc",    32'(pc), 32'd0);
    chk("mid_valid_d2", 32'(bus2.instr_valid), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_instr", 32'(bus.instr), 32'h0);
    chk("post_rst_zcnt",  32'(zero_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/emisor_instrucciones.md
# emisor_instrucciones

Program sequencer driving the 20-bit instruction word consumed by the register-file/ALU datapath (`in[19]` read-bank write enable, `in[18]` result-bank write enable, `in[17:13]` source 1, `in[12:10]` ALU select, `in[9:5]` source 2, `in[4:0]` destination).
- Host loads a short program into an internal buffer.
- On `start`, the block issues the program one word per accepted handshake.
- It counts zero-flag results returned by the ALU and pulses `done` at the end.

## Interface
- `DEPTH`, 16, program buffer entries (power of two, ≥2)
- `IW`, 20, instruction word width (fixed by datapath format)
- `ZW`, 8, width of zero-result counter
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `wr_en` in 1: append `wr_data` to buffer (IDLE only)
- `wr_data` in IW: instruction word to append
- `clr` in 1: empty the buffer (IDLE only)
- `start` in 1: begin issuing the loaded program
- `instr_ready` in 1: datapath accepts `instr` this cycle
- `zflow` in 1: datapath zero flag for the word currently on `instr`
- `instr` out IW: instruction word to datapath
- `instr_valid` out 1: `instr` is valid
- `busy` out 1: state is RUN
- `done` out 1: one-cycle pulse at program end
- `pc` out $clog2(DEPTH): index of word on `instr`
- `count` out $clog2(DEPTH)+1: number of loaded words
- `zero_cnt` out ZW: accepted words with `zflow`=1, saturating

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- All outputs are registered.
- Reset values: `instr`=0, `instr_valid`=0, `busy`=0, `done`=0, `pc`=0, `count`=0, `zero_cnt`=0. Buffer contents are don't-care.
- IDLE, buffer loading and clearing:
  - `clr`=1: `count`<=0. `clr` has priority over `wr_en` and `start`.
  - `wr_en`=1 and `count`<DEPTH: buffer[`count`]<=`wr_data`, `count`++.
  - `wr_en`=1 and `count`=DEPTH: write dropped, `count` unchanged.
  - `wr_en` and `start` in the same cycle: write performed, `start` ignored.
- IDLE, `start`=1 (no `clr`/`wr_en`):
  - If `count`>0: `instr`<=buffer[0], `instr_valid`<=1, `pc`<=0, `zero_cnt`<=0, go to RUN.
  - If `count`=0: `zero_cnt`<=0, go to DONE. No word is issued.
- RUN, handshake and issue:
  - Accept occurs when `instr_valid` & `instr_ready`.
  - On accept, if `zflow`=1: `zero_cnt`++, saturating at 2^ZW−1.
  - On accept with `pc`<`count`−1: `pc`++, `instr`<=buffer[`pc`+1]; `instr_valid` stays 1.
  - On accept with `pc`=`count`−1: `instr_valid`<=0, go to DONE.
  - No accept: `instr`, `pc` and `instr_valid` hold.
  - `zflow` is ignored when there is no accept.
- RUN, ignored inputs: `wr_en`, `clr` and `start` have no effect.
- DONE: `done`=1 for exactly one cycle, then IDLE.
  - Buffer and `count` are retained, so a later `start` reruns the same program.
  - `zero_cnt` holds until the next `start`.
- `busy`=1 iff state is RUN.
- `instr` keeps its last value when `instr_valid`=0.
- Reset mid-RUN: immediate return to reset values. `count`=0, so the program is lost.

## Timing
- `start` sampled at edge N: `instr_valid`=1 with buffer[0] after edge N.
- One word per cycle when `instr_ready` is held at 1.
- Program of length L with continuous ready:
  - `instr_valid` is high for L cycles.
  - `done` is high in the cycle after the last accept.
  - Back in IDLE one cycle later.
- `start` to `done` latency: L+1 cycles with continuous ready. Each ready-low cycle in RUN adds one cycle.
- `zflow` is combinational from the datapath and is sampled at the same edge as the accept.
- `count` and `pc` update at the edge following the request. No combinational paths from inputs to outputs.

## Test plan
- Reset then idle: all outputs 0. Pulse `rst` mid-RUN after 2 accepts → next cycle `instr_valid`=0, `busy`=0, `count`=0.
- Load 3 words 0x8A0C1, 0x40421, 0xC1463; `start` with `instr_ready`=1 → `instr` = those words on 3 consecutive cycles, `pc`=0,1,2; `done` pulse on cycle 4; `count` remains 3.
- Same program, `instr_ready` low for 2 cycles while word 1 is shown → word 1 held 3 cycles, `pc`=1 held; `done` at start+6.
- Write 17 words with DEPTH=16 → `count`=16, 17th dropped. Write in RUN → ignored. `clr` with `wr_en` → `count`=0.
- `start` with `count`=0 → no `instr_valid`, `done` pulse one cycle after `start`. `start` with `wr_en` → word stored, stays IDLE.
- 4-word run, `zflow`=1 on accepts 1 and 3 only, plus `zflow`=1 during a non-accept cycle → `zero_cnt`=2. Rerun with all-`zflow`, ZW=2 and 4 words → `zero_cnt`=3 (saturated).
